// File: rtl/conv_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_addr_gen_pkg
// Description : Shared widths, pipeline depth and flag bundle type for the
//               convolution address generator and its configuration block.
//               c_data_size  - width of layer dimension inputs
//               c_loop_bit   - width of loop indices
//               c_addr_w     - width of every generated address
//               c_pipe_depth - number of pipeline stages (valid chain length)
// Revision    : 1.0 - initial release
// ============================================================================
package conv_addr_gen_pkg;

    localparam int c_data_size  = 16;
    localparam int c_loop_bit   = 8;
    localparam int c_addr_w     = 20;
    localparam int c_pipe_depth = 3;

    // Accumulation / layer markers travelling alongside each tuple.
    typedef struct packed {
        logic first;
        logic last;
        logic layer;
    } acc_flags_t;

endpackage : conv_addr_gen_pkg
`default_nettype wire

// File: rtl/conv_addr_cfg.sv
`default_nettype none
// ============================================================================
// Module      : conv_addr_cfg
// Description : Layer constant registers for the address generator. Latches
//               the layer dimensions on an accepted cfg_load (pipeline idle)
//               and precomputes the plane sizes used by the address datapath.
//               A cfg_load while the pipeline is busy is dropped and reported
//               with a one-cycle cfg_err pulse.
// Ports       : clk, rst (async, active-high)
//               cfg_load, busy         - load request / pipeline occupancy
//               R, C, M, N, K          - layer dimensions
//               cfg_valid, cfg_err     - status
//               iw, pin, pout, kk      - derived constants (ADDR_W)
//               kr, cr, nr             - kernel size, output cols, input maps
//               kr_m1 .. r_m1          - last-index values for flag compares
// Revision    : 1.0 - initial release
// ============================================================================
module conv_addr_cfg
    import conv_addr_gen_pkg::*;
#(
    parameter int DATA_SIZE = c_data_size,
    parameter int ADDR_W    = c_addr_w
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_load,
    input  logic                 busy,
    input  logic [DATA_SIZE-1:0] R,
    input  logic [DATA_SIZE-1:0] C,
    input  logic [DATA_SIZE-1:0] M,
    input  logic [DATA_SIZE-1:0] N,
    input  logic [DATA_SIZE-1:0] K,
    output logic                 cfg_valid,
    output logic                 cfg_err,
    output logic [ADDR_W-1:0]    iw,
    output logic [ADDR_W-1:0]    pin,
    output logic [ADDR_W-1:0]    pout,
    output logic [ADDR_W-1:0]    kk,
    output logic [ADDR_W-1:0]    kr,
    output logic [ADDR_W-1:0]    cr,
    output logic [ADDR_W-1:0]    nr,
    output logic [DATA_SIZE-1:0] kr_m1,
    output logic [DATA_SIZE-1:0] cr_m1,
    output logic [DATA_SIZE-1:0] nr_m1,
    output logic [DATA_SIZE-1:0] m_m1,
    output logic [DATA_SIZE-1:0] r_m1
);

    logic                 w_accept;
    logic [ADDR_W-1:0]    w_iw;
    logic [ADDR_W-1:0]    w_ih;

    logic                 r_cfg_valid;
    logic                 r_cfg_err;
    logic [ADDR_W-1:0]    r_iw;
    logic [ADDR_W-1:0]    r_pin;
    logic [ADDR_W-1:0]    r_pout;
    logic [ADDR_W-1:0]    r_kk;
    logic [DATA_SIZE-1:0] r_k;
    logic [DATA_SIZE-1:0] r_c;
    logic [DATA_SIZE-1:0] r_n;
    logic [DATA_SIZE-1:0] r_m;
    logic [DATA_SIZE-1:0] r_r;

    // Constants may only change while no tuple is in flight, so every tuple
    // sees a single consistent layer description through all stages.
    assign w_accept = cfg_load && !busy;

    // Stride 1, no padding: input plane is the output plane grown by K-1.
    assign w_iw = ADDR_W'(C) + ADDR_W'(K) - ADDR_W'(1);
    assign w_ih = ADDR_W'(R) + ADDR_W'(K) - ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_iw        <= '0;
            r_pin       <= '0;
            r_pout      <= '0;
            r_kk        <= '0;
            r_k         <= '0;
            r_c         <= '0;
            r_n         <= '0;
            r_m         <= '0;
            r_r         <= '0;
        end else begin
            r_cfg_err <= cfg_load && busy;
            if (w_accept) begin
                r_cfg_valid <= 1'b1;
                r_iw        <= w_iw;
                r_pin       <= w_ih * w_iw;
                r_pout      <= ADDR_W'(R) * ADDR_W'(C);
                r_kk        <= ADDR_W'(K) * ADDR_W'(K);
                r_k         <= K;
                r_c         <= C;
                r_n         <= N;
                r_m         <= M;
                r_r         <= R;
            end
        end
    end

    assign cfg_valid = r_cfg_valid;
    assign cfg_err   = r_cfg_err;
    assign iw        = r_iw;
    assign pin       = r_pin;
    assign pout      = r_pout;
    assign kk        = r_kk;
    assign kr        = ADDR_W'(r_k);
    assign cr        = ADDR_W'(r_c);
    assign nr        = ADDR_W'(r_n);

    // A zero dimension wraps to all-ones here, so its "last" flag never fires.
    assign kr_m1     = r_k - DATA_SIZE'(1);
    assign cr_m1     = r_c - DATA_SIZE'(1);
    assign nr_m1     = r_n - DATA_SIZE'(1);
    assign m_m1      = r_m - DATA_SIZE'(1);
    assign r_m1      = r_r - DATA_SIZE'(1);

endmodule : conv_addr_cfg
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_addr_gen
// Description : Three-stage address generator for a convolution loop nest.
//               Each accepted (rr,cc,mm,nn,ii,jj) tuple yields input-map,
//               weight and output addresses plus accumulate-first/last and
//               layer-last flags. The whole pipeline advances together when
//               the output slot is free or being consumed, else it freezes.
// Ports       : clk, rst (async, active-high)
//               cfg_load, R, C, M, N, K, cfg_valid, cfg_err - layer config
//               busy                                        - any stage valid
//               in_valid/in_ready, rr..jj                   - index tuple in
//               out_valid/out_ready, in_addr, w_addr, o_addr,
//               acc_first, acc_last, layer_last             - result out
// Revision    : 1.0 - initial release
// ============================================================================
module conv_addr_gen
    import conv_addr_gen_pkg::*;
#(
    parameter int DATA_SIZE = c_data_size,
    parameter int LOOP_BIT  = c_loop_bit,
    parameter int ADDR_W    = c_addr_w
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_load,
    input  logic [DATA_SIZE-1:0] R,
    input  logic [DATA_SIZE-1:0] C,
    input  logic [DATA_SIZE-1:0] M,
    input  logic [DATA_SIZE-1:0] N,
    input  logic [DATA_SIZE-1:0] K,
    output logic                 cfg_valid,
    output logic                 cfg_err,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LOOP_BIT-1:0]  rr,
    input  logic [LOOP_BIT-1:0]  cc,
    input  logic [LOOP_BIT-1:0]  mm,
    input  logic [LOOP_BIT-1:0]  nn,
    input  logic [LOOP_BIT-1:0]  ii,
    input  logic [LOOP_BIT-1:0]  jj,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    in_addr,
    output logic [ADDR_W-1:0]    w_addr,
    output logic [ADDR_W-1:0]    o_addr,
    output logic                 acc_first,
    output logic                 acc_last,
    output logic                 layer_last
);

    // ---------------------------------------------------------------------
    // Layer constants
    // ---------------------------------------------------------------------
    logic                 w_cfg_valid;
    logic [ADDR_W-1:0]    w_iw, w_pin, w_pout, w_kk, w_kr, w_cr, w_nr;
    logic [DATA_SIZE-1:0] w_kr_m1, w_cr_m1, w_nr_m1, w_m_m1, w_r_m1;
    logic                 w_busy;

    conv_addr_cfg #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_W    (ADDR_W)
    ) u_cfg (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .busy      (w_busy),
        .R         (R),
        .C         (C),
        .M         (M),
        .N         (N),
        .K         (K),
        .cfg_valid (w_cfg_valid),
        .cfg_err   (cfg_err),
        .iw        (w_iw),
        .pin       (w_pin),
        .pout      (w_pout),
        .kk        (w_kk),
        .kr        (w_kr),
        .cr        (w_cr),
        .nr        (w_nr),
        .kr_m1     (w_kr_m1),
        .cr_m1     (w_cr_m1),
        .nr_m1     (w_nr_m1),
        .m_m1      (w_m_m1),
        .r_m1      (w_r_m1)
    );

    // ---------------------------------------------------------------------
    // Handshake / valid chain
    // ---------------------------------------------------------------------
    logic [c_pipe_depth-1:0] r_vld;
    logic                    w_adv;
    logic                    w_in_ready;
    logic                    w_in_fire;

    // Output slot free or draining: every stage may move one step.
    assign w_adv      = !r_vld[c_pipe_depth-1] || out_ready;
    assign w_in_ready = w_adv && w_cfg_valid;
    assign w_in_fire  = in_valid && w_in_ready;
    assign w_busy     = |r_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else if (w_adv) begin
            // A cycle without a transfer shifts in a bubble.
            r_vld <= {r_vld[c_pipe_depth-2:0], w_in_fire};
        end
    end

    // ---------------------------------------------------------------------
    // Stage 1: plane coordinates, combined map index, flags
    // ---------------------------------------------------------------------
    acc_flags_t          w_s1_flg;
    logic                w_l;

    always_comb begin
        w_l            = (DATA_SIZE'(nn) == w_nr_m1) &&
                         (DATA_SIZE'(ii) == w_kr_m1) &&
                         (DATA_SIZE'(jj) == w_kr_m1);
        w_s1_flg.first = (nn == '0) && (ii == '0) && (jj == '0);
        w_s1_flg.last  = w_l;
        w_s1_flg.layer = w_l &&
                         (DATA_SIZE'(mm) == w_m_m1) &&
                         (DATA_SIZE'(cc) == w_cr_m1) &&
                         (DATA_SIZE'(rr) == w_r_m1);
    end

    logic [ADDR_W-1:0]   r1_row, r1_col, r1_mn;
    logic [LOOP_BIT-1:0] r1_nn, r1_ii, r1_jj, r1_mm, r1_rr, r1_cc;
    acc_flags_t          r1_flg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_row <= '0;
            r1_col <= '0;
            r1_mn  <= '0;
            r1_nn  <= '0;
            r1_ii  <= '0;
            r1_jj  <= '0;
            r1_mm  <= '0;
            r1_rr  <= '0;
            r1_cc  <= '0;
            r1_flg <= '0;
        end else if (w_adv && w_in_fire) begin
            r1_row <= ADDR_W'(rr) + ADDR_W'(ii);
            r1_col <= ADDR_W'(cc) + ADDR_W'(jj);
            r1_mn  <= ADDR_W'(mm) * w_nr + ADDR_W'(nn);
            r1_nn  <= nn;
            r1_ii  <= ii;
            r1_jj  <= jj;
            r1_mm  <= mm;
            r1_rr  <= rr;
            r1_cc  <= cc;
            r1_flg <= w_s1_flg;
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: row/plane bases (the multiplies)
    // ---------------------------------------------------------------------
    logic [ADDR_W-1:0]   r2_ia, r2_wa, r2_oa, r2_col;
    logic [LOOP_BIT-1:0] r2_jj, r2_cc;
    acc_flags_t          r2_flg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_ia  <= '0;
            r2_wa  <= '0;
            r2_oa  <= '0;
            r2_col <= '0;
            r2_jj  <= '0;
            r2_cc  <= '0;
            r2_flg <= '0;
        end else if (w_adv && r_vld[0]) begin
            r2_ia  <= ADDR_W'(r1_nn) * w_pin + r1_row * w_iw;
            r2_wa  <= r1_mn * w_kk + ADDR_W'(r1_ii) * w_kr;
            r2_oa  <= ADDR_W'(r1_mm) * w_pout + ADDR_W'(r1_rr) * w_cr;
            r2_col <= r1_col;
            r2_jj  <= r1_jj;
            r2_cc  <= r1_cc;
            r2_flg <= r1_flg;
        end
    end

    // ---------------------------------------------------------------------
    // Stage 3: column offsets, registered outputs
    // ---------------------------------------------------------------------
    logic [ADDR_W-1:0] r3_in, r3_w, r3_o;
    acc_flags_t        r3_flg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_in  <= '0;
            r3_w   <= '0;
            r3_o   <= '0;
            r3_flg <= '0;
        end else if (w_adv && r_vld[1]) begin
            r3_in  <= r2_ia + r2_col;
            r3_w   <= r2_wa + ADDR_W'(r2_jj);
            r3_o   <= r2_oa + ADDR_W'(r2_cc);
            r3_flg <= r2_flg;
        end
    end

    assign cfg_valid  = w_cfg_valid;
    assign busy       = w_busy;
    assign in_ready   = w_in_ready;
    assign out_valid  = r_vld[c_pipe_depth-1];
    assign in_addr    = r3_in;
    assign w_addr     = r3_w;
    assign o_addr     = r3_o;
    assign acc_first  = r3_flg.first;
    assign acc_last   = r3_flg.last;
    assign layer_last = r3_flg.layer;

endmodule : conv_addr_gen
`default_nettype wire

// File: tb/tb_conv_addr_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_conv_addr_gen
// Description : Self-checking bench for conv_addr_gen. Expected results come
//               from a flat-index model of the loop nest (NCHW-style input,
//               MNKK weights, MRC outputs) taken modulo 2^ADDR_W.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_addr_gen;

    localparam int DS = 16;
    localparam int LB = 8;
    localparam int AW = 20;

    typedef struct {
        int r, c, m, n, k;
    } cfg_t;

    typedef struct packed {
        logic [AW-1:0] ia;
        logic [AW-1:0] wa;
        logic [AW-1:0] oa;
        logic          f;
        logic          l;
        logic          ll;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_load = 1'b0;
    logic [DS-1:0] R = '0, C = '0, M = '0, N = '0, K = '0;
    logic          cfg_valid, cfg_err, busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LB-1:0] rr = '0, cc = '0, mm = '0, nn = '0, ii = '0, jj = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] in_addr, w_addr, o_addr;
    logic          acc_first, acc_last, layer_last;

    int   n_checks = 0;
    int   n_errors = 0;
    cfg_t m_cfg;
    rec_t exp_q[$];
    rec_t got_q[$];

    always #5 clk = ~clk;

    conv_addr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .R          (R),
        .C          (C),
        .M          (M),
        .N          (N),
        .K          (K),
        .cfg_valid  (cfg_valid),
        .cfg_err    (cfg_err),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rr         (rr),
        .cc         (cc),
        .mm         (mm),
        .nn         (nn),
        .ii         (ii),
        .jj         (jj),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .in_addr    (in_addr),
        .w_addr     (w_addr),
        .o_addr     (o_addr),
        .acc_first  (acc_first),
        .acc_last   (acc_last),
        .layer_last (layer_last)
    );

    // Flat-index reference: position of the element in each buffer.
    function automatic rec_t model(cfg_t g, int r, int c, int m, int n, int i, int j);
        rec_t   e;
        longint iw, ih, in_idx, w_idx, o_idx;
        iw     = longint'(g.c + g.k - 1);
        ih     = longint'(g.r + g.k - 1);
        in_idx = (longint'(n) * ih + longint'(r + i)) * iw + longint'(c + j);
        w_idx  = ((longint'(m) * g.n + n) * g.k + i) * g.k + j;
        o_idx  = (longint'(m) * g.r + r) * g.c + c;
        e.ia   = in_idx[AW-1:0];
        e.wa   = w_idx[AW-1:0];
        e.oa   = o_idx[AW-1:0];
        e.f    = (n == 0) && (i == 0) && (j == 0);
        e.l    = (n == g.n - 1) && (i == g.k - 1) && (j == g.k - 1);
        e.ll   = e.l && (m == g.m - 1) && (c == g.c - 1) && (r == g.r - 1);
        return e;
    endfunction

    function automatic logic [LB-1:0] rnd_idx(int d);
        if (d > 256 || d < 1 || $urandom_range(7) == 0)
            return LB'($urandom_range(255));
        return LB'($urandom_range(d - 1));
    endfunction

    // One clock: record transfers on both sides, then advance to next negedge.
    task automatic tick();
        #1;
        if (in_valid && in_ready)
            exp_q.push_back(model(m_cfg, int'(rr), int'(cc), int'(mm), int'(nn), int'(ii), int'(jj)));
        if (out_valid && out_ready)
            got_q.push_back({in_addr, w_addr, o_addr, acc_first, acc_last, layer_last});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_cfg(cfg_t g);
        R = DS'(g.r); C = DS'(g.c); M = DS'(g.m); N = DS'(g.n); K = DS'(g.k);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        m_cfg = g;
    endtask

    task automatic set_tuple(int r, int c, int m, int n, int i, int j);
        rr = LB'(r); cc = LB'(c); mm = LB'(m); nn = LB'(n); ii = LB'(i); jj = LB'(j);
    endtask

    task automatic drain(string tag);
        int cnt;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        while (busy && cnt < 20) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_drain_timeout: busy=%0b required 0", tag, busy);
        end
    endtask

    task automatic compare_queues(string tag);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL %s_count: emitted %0d required %0d", tag, got_q.size(), exp_q.size());
        end
        for (int q = 0; q < exp_q.size() && q < got_q.size(); q++) begin
            n_checks++;
            if (got_q[q] !== exp_q[q]) begin
                n_errors++;
                $display("FAIL %s_item%0d: got in=%0d w=%0d o=%0d f/l/ll=%b%b%b required in=%0d w=%0d o=%0d f/l/ll=%b%b%b",
                         tag, q, got_q[q].ia, got_q[q].wa, got_q[q].oa, got_q[q].f, got_q[q].l, got_q[q].ll,
                         exp_q[q].ia, exp_q[q].wa, exp_q[q].oa, exp_q[q].f, exp_q[q].l, exp_q[q].ll);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, cfg_valid, cfg_err, busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_status: got ov/cv/ce/busy=%b required 0000",
                     {out_valid, cfg_valid, cfg_err, busy});
        end
        n_checks++;
        if ({in_addr, w_addr, o_addr} !== '0 || {acc_first, acc_last, layer_last} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_outputs: got in=%0d w=%0d o=%0d flags=%b%b%b required all 0",
                     in_addr, w_addr, o_addr, acc_first, acc_last, layer_last);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_unconfigured: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        in_valid = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_config();
        cfg_t g;
        g = '{r: 4, c: 4, m: 2, n: 3, k: 3};
        R = 4; C = 4; M = 2; N = 3; K = 3;
        cfg_load = 1'b1;
        #1;
        n_checks++;
        if (cfg_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL cfg_valid_early: got %b required 0", cfg_valid);
        end
        tick();
        cfg_load = 1'b0;
        m_cfg = g;
        n_checks++;
        if (cfg_valid !== 1'b1 || cfg_err !== 1'b0) begin
            n_errors++;
            $display("FAIL cfg_load_idle: cfg_valid=%b cfg_err=%b required 1 0", cfg_valid, cfg_err);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL cfg_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        int tr[3][6];
        int ex[3][6];
        int lat;
        tr = '{'{0, 0, 0, 0, 0, 0}, '{1, 2, 1, 2, 1, 2}, '{3, 3, 1, 2, 2, 2}};
        ex = '{'{0, 0, 0, 1, 0, 0}, '{88, 50, 22, 0, 0, 0}, '{107, 53, 31, 0, 1, 1}};
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            set_tuple(tr[t][0], tr[t][1], tr[t][2], tr[t][3], tr[t][4], tr[t][5]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            n_checks++;
            if (lat != 3) begin
                n_errors++;
                $display("FAIL directed%0d_latency: got %0d cycles required 3", t, lat);
            end
            n_checks++;
            if (int'(in_addr) != ex[t][0] || int'(w_addr) != ex[t][1] || int'(o_addr) != ex[t][2] ||
                int'(acc_first) != ex[t][3] || int'(acc_last) != ex[t][4] || int'(layer_last) != ex[t][5]) begin
                n_errors++;
                $display("FAIL directed%0d_result: got in=%0d w=%0d o=%0d f/l/ll=%b%b%b required in=%0d w=%0d o=%0d f/l/ll=%0d%0d%0d",
                         t, in_addr, w_addr, o_addr, acc_first, acc_last, layer_last,
                         ex[t][0], ex[t][1], ex[t][2], ex[t][3], ex[t][4], ex[t][5]);
            end
            tick();
        end
        compare_queues("directed");
    endtask

    task automatic test_back_to_back();
        rec_t snap;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int t = 0; t < 10; t++) begin
            set_tuple(rnd_idx(4), rnd_idx(4), rnd_idx(2), rnd_idx(3), rnd_idx(3), rnd_idx(3));
            tick();
        end
        snap = '0;
        for (int s = 0; s < 4; s++) begin
            out_ready = 1'b0;
            set_tuple(rnd_idx(4), rnd_idx(4), rnd_idx(2), rnd_idx(3), rnd_idx(3), rnd_idx(3));
            #1;
            if (s == 0) snap = {in_addr, w_addr, o_addr, acc_first, acc_last, layer_last};
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL stall%0d_handshake: in_ready=%b out_valid=%b required 0 1", s, in_ready, out_valid);
            end
            n_checks++;
            if ({in_addr, w_addr, o_addr, acc_first, acc_last, layer_last} !== snap) begin
                n_errors++;
                $display("FAIL stall%0d_frozen: got in=%0d w=%0d o=%0d required in=%0d w=%0d o=%0d",
                         s, in_addr, w_addr, o_addr, snap.ia, snap.wa, snap.oa);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            set_tuple(rnd_idx(4), rnd_idx(4), rnd_idx(2), rnd_idx(3), rnd_idx(3), rnd_idx(3));
            tick();
        end
        drain("b2b");
        compare_queues("b2b");
    endtask

    task automatic test_random_stream();
        cfg_t g;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0)
                g = '{r: int'($urandom_range(1, 8)), c: int'($urandom_range(1, 8)),
                      m: int'($urandom_range(1, 4)), n: int'($urandom_range(1, 4)),
                      k: int'($urandom_range(1, 4))};
            else
                g = '{r: int'($urandom_range(1000, 65535)), c: int'($urandom_range(1000, 65535)),
                      m: int'($urandom_range(300, 65535)), n: int'($urandom_range(300, 65535)),
                      k: int'($urandom_range(1, 65535))};
            load_cfg(g);
            for (int t = 0; t < 150; t++) begin
                in_valid  = ($urandom_range(3) != 0);
                out_ready = ($urandom_range(3) != 0);
                set_tuple(rnd_idx(g.r), rnd_idx(g.c), rnd_idx(g.m), rnd_idx(g.n), rnd_idx(g.k), rnd_idx(g.k));
                tick();
            end
            drain($sformatf("random%0d", ph));
            compare_queues($sformatf("random%0d", ph));
        end
    endtask

    task automatic test_cfg_busy();
        cfg_t g;
        g = '{r: 4, c: 4, m: 2, n: 3, k: 3};
        load_cfg(g);
        out_ready = 1'b1;
        set_tuple(1, 2, 1, 2, 1, 2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        R = 5; C = 7; M = 1; N = 1; K = 1;
        cfg_load = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL cfgbusy_busy: got %b required 1", busy);
        end
        tick();
        cfg_load = 1'b0;
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_errors++;
            $display("FAIL cfgbusy_err_pulse: got %b required 1", cfg_err);
        end
        tick();
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_errors++;
            $display("FAIL cfgbusy_err_clear: got %b required 0", cfg_err);
        end
        drain("cfgbusy");
        set_tuple(3, 3, 1, 2, 2, 2);
        in_valid = 1'b1;
        tick();
        drain("cfgbusy2");
        n_checks++;
        if (got_q.size() == 2 && (got_q[0].ia !== 20'd88 || got_q[1].ia !== 20'd107 || got_q[1].ll !== 1'b1)) begin
            n_errors++;
            $display("FAIL cfgbusy_old_consts: got in=%0d,%0d ll=%b required 88,107 1",
                     got_q[0].ia, got_q[1].ia, got_q[1].ll);
        end
        compare_queues("cfgbusy");
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int t = 0; t < 2; t++) begin
            set_tuple(rnd_idx(4), rnd_idx(4), rnd_idx(2), rnd_idx(3), rnd_idx(3), rnd_idx(3));
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || cfg_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_immediate: out_valid=%b busy=%b cfg_valid=%b required 0 0 0",
                     out_valid, busy, cfg_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        in_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL midrst_idle%0d: in_ready=%b out_valid=%b required 0 0", t, in_ready, out_valid);
            end
            tick();
        end
        in_valid = 1'b0;
        load_cfg('{r: 4, c: 4, m: 2, n: 3, k: 3});
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || got_q.size() != 0) begin
            n_errors++;
            $display("FAIL midrst_reload: in_ready=%b stray_outputs=%0d required 1 0", in_ready, got_q.size());
        end
    endtask

    initial begin
        m_cfg = '{r: 0, c: 0, m: 0, n: 0, k: 0};
        test_reset();
        test_config();
        test_directed();
        test_back_to_back();
        test_random_stream();
        test_cfg_busy();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_conv_addr_gen
`default_nettype wire
